// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
// Optional counters are enabled with MEM_ARB_PERF_EN (see mem_arb_perf).
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} arb_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side handshake bundle of the arbiter.
// slave = arbiter view, master = pipeline plus memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata, m_be,
               stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata, m_be,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arb_perf.sv
// Saturating stall/kill event counters, built only under MEM_ARB_PERF_EN.
module mem_arb_perf
  import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_if,
    input  logic        inc_d,
    input  logic        inc_kill,
    output logic [31:0] perf_if_stall_cnt,
    output logic [31:0] perf_d_stall_cnt,
    output logic [31:0] perf_kill_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_cnt <= '0;
            perf_d_stall_cnt  <= '0;
            perf_kill_cnt     <= '0;
        end else begin
            perf_if_stall_cnt <= sat_inc(perf_if_stall_cnt, inc_if);
            perf_d_stall_cnt  <= sat_inc(perf_d_stall_cnt, inc_d);
            perf_kill_cnt     <= sat_inc(perf_kill_cnt, inc_kill);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, data first.
// Define MEM_ARB_PERF_EN to add saturating stall/kill counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_if_stall_cnt,
    output logic [31:0] perf_d_stall_cnt,
    output logic [31:0] perf_kill_cnt,
`endif
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    arb_state_e        state, state_nxt;
    logic              is_d;
    logic              kill_pending;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [BE_W-1:0]   m_be_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              busy, grant_d, grant_i;
    logic              if_valid_w, d_valid_w, if_drop, stall_mem_w, stall_if_w;

    assign busy    = (state == D_BUSY) || (state == I_BUSY);
    assign grant_d = (state == IDLE) && bus.d_req;
    assign grant_i = (state == IDLE) && !bus.d_req && bus.if_req && !bus.if_kill;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (grant_d) state_nxt = D_BUSY;
                            else if (grant_i) state_nxt = I_BUSY;
            D_BUSY, I_BUSY: if (bus.m_ack) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            is_d         <= 1'b0;
            kill_pending <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                is_d      <= 1'b1;
                m_we_q    <= bus.d_we;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
                m_be_q    <= bus.d_be;
            end else if (grant_i) begin
                is_d     <= 1'b0;
                m_we_q   <= 1'b0;
                m_addr_q <= bus.if_addr;
                m_be_q   <= '1;
            end
            if (busy && bus.m_ack) begin
                if (is_d) d_rdata_q  <= bus.m_rdata;
                else      if_rdata_q <= bus.m_rdata;
            end
            // DONE always leads to IDLE, so leaving DONE is the clear point
            if (state == DONE)
                kill_pending <= 1'b0;
            else if (state == I_BUSY && bus.if_kill)
                kill_pending <= 1'b1;
        end
    end

    // A kill arriving in the DONE cycle itself must also swallow the pulse
    assign if_drop     = (state == DONE) && !is_d && (kill_pending || bus.if_kill);
    assign if_valid_w  = (state == DONE) && !is_d && !kill_pending && !bus.if_kill;
    assign d_valid_w   = (state == DONE) && is_d;
    assign stall_mem_w = bus.d_req && !d_valid_w;
    assign stall_if_w  = stall_mem_w || (bus.if_req && !if_valid_w && !bus.if_kill);

    assign bus.m_req     = busy;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_be      = m_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_valid  = if_valid_w;
    assign bus.d_valid   = d_valid_w;
    assign bus.stall_mem = stall_mem_w;
    assign bus.stall_if  = stall_if_w;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk               (clk),
        .rst_n             (rst_n),
        .inc_if            (stall_if_w),
        .inc_d             (stall_mem_w),
        .inc_kill          (if_drop),
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_d_stall_cnt  (perf_d_stall_cnt),
        .perf_kill_cnt     (perf_kill_cnt)
    );
`else
    logic unused_drop;
    assign unused_drop = if_drop;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed fetch/load/store/kill/reset cases.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          w;
    } bus_t;

    typedef struct {
        logic        load;
        logic [31:0] rdata;
    } dresp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    bus_t        exp_bus[$];
    logic [31:0] exp_if[$];
    dresp_t      exp_d[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_if, p_d, p_k;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef MEM_ARB_PERF_EN
        .perf_if_stall_cnt (p_if),
        .perf_d_stall_cnt  (p_d),
        .perf_kill_cnt     (p_k),
`endif
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected event want none", name);
    endtask

    // Response monitor: pops the scoreboard whenever a valid pulse appears
    initial forever begin
        @(negedge clk);
        if (bus.if_valid) begin
            if (exp_if.size() == 0) fail("if_valid_unexpected");
            else chk("if_rdata", bus.if_rdata, exp_if.pop_front());
        end
        if (bus.d_valid) begin
            if (exp_d.size() == 0) fail("d_valid_unexpected");
            else begin
                dresp_t e;
                e = exp_d.pop_front();
                if (e.load) chk("d_rdata", bus.d_rdata, e.rdata);
            end
        end
    end

    // Memory model: checks each new request against the expected bus op, acks after w extra cycles
    initial begin
        bit   active = 0;
        int   cnt = 0;
        bus_t cur;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_ack = 1'b0;
            if (!bus.m_req) active = 0;
            else begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (exp_bus.size() == 0) begin
                        fail("m_req_unexpected");
                        cur = '{1'b0, bus.m_addr, 32'h0, 4'h0, 32'h0, 0};
                    end else begin
                        cur = exp_bus.pop_front();
                        chk("m_we", {31'b0, bus.m_we}, {31'b0, cur.we});
                        chk("m_be", {28'b0, bus.m_be}, {28'b0, cur.be});
                        if (cur.we) chk("m_wdata", bus.m_wdata, cur.wdata);
                    end
                end
                chk("m_addr", bus.m_addr, cur.addr);
                if (cnt == cur.w) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = cur.rdata;
                    active = 0;
                end
                cnt++;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata, input int w);
        int lat = 0;
        bit st_ok = 1;
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        exp_bus.push_back('{1'b0, addr, 32'h0, 4'hF, rdata, w});
        exp_if.push_back(rdata);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.if_valid) break;
            if (!bus.stall_if) st_ok = 0;
            lat++;
        end
        bus.if_req = 1'b0;
        chk("fetch_latency", lat, w + 2);
        chk("fetch_stall_if", {31'b0, st_ok}, 32'd1);
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata, input int w);
        int lat = 0;
        int nif = 0;
        bit st_ok = 1;
        @(posedge clk); #1;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_be    = be;
        exp_bus.push_back('{we, addr, wdata, be, rdata, w});
        exp_d.push_back('{!we, rdata});
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.if_valid) nif++;
            if (bus.d_valid) break;
            if (!bus.stall_mem) st_ok = 0;
            lat++;
        end
        bus.d_req = 1'b0;
        chk("data_latency", lat, w + 2);
        chk("data_stall_mem", {31'b0, st_ok}, 32'd1);
        chk("data_no_if_valid", nif, 0);
    endtask

    initial begin
        int nv;
        int d_cyc, i_cyc;
        bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;

        repeat (2) @(negedge clk);
        chk("rst_m_req", {31'b0, bus.m_req}, 32'd0);
        chk("rst_m_we", {31'b0, bus.m_we}, 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_m_be", {28'b0, bus.m_be}, 32'd0);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_d_valid", {31'b0, bus.d_valid}, 32'd0);
        chk("rst_stalls", {30'b0, bus.stall_if, bus.stall_mem}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fetch only, ack in cycle 3 -> valid in cycle 4; then minimum latency
        do_fetch(32'h100, 32'h0050_0093, 2);
        do_fetch(32'h104, 32'h0010_0113, 0);

        // Collision: data first, then fetch restarts from IDLE
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h108;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_be = 4'hF;
        exp_bus.push_back('{1'b0, 32'h2000, 32'h0, 4'hF, 32'h1234_5678, 0});
        exp_bus.push_back('{1'b0, 32'h108, 32'h0, 4'hF, 32'h00a0_0113, 0});
        exp_d.push_back('{1'b1, 32'h1234_5678});
        exp_if.push_back(32'h00a0_0113);
        d_cyc = -1; i_cyc = -1; nv = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.d_valid) begin bus.d_req = 0; d_cyc = c; end
            if (bus.if_valid) begin bus.if_req = 0; i_cyc = c; break; end
            if (!bus.stall_if) nv++;
        end
        bus.d_req = 0; bus.if_req = 0;
        chk("coll_d_cycle", d_cyc, 2);
        chk("coll_if_cycle", i_cyc, 5);
        chk("coll_stall_if", nv, 0);

        // Store with partial byte enables
        do_data(1'b1, 32'h3000, 32'h0000_ABCD, 4'b0011, 32'hDEAD_BEEF, 1);

        // Kill in flight: fetch completes on the bus, no if_valid
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h200;
        exp_bus.push_back('{1'b0, 32'h200, 32'h0, 4'hF, 32'h1111_1111, 3});
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.if_kill = 1; bus.if_req = 0;
        @(negedge clk);
        chk("kill_m_req_held", {31'b0, bus.m_req}, 32'd1);
        @(posedge clk); #1 bus.if_kill = 0;
        nv = 0;
        repeat (6) begin @(negedge clk); if (bus.if_valid) nv++; end
        chk("kill_no_if_valid", nv, 0);
        chk("kill_bus_done", exp_bus.size(), 0);
        do_fetch(32'h300, 32'h0030_0193, 1);

        // Reset mid data access
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4000; bus.d_be = 4'hF;
        exp_bus.push_back('{1'b0, 32'h4000, 32'h0, 4'hF, 32'h0BAD_0BAD, 50});
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_m_req_before", {31'b0, bus.m_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_m_req_drop", {31'b0, bus.m_req}, 32'd0);
        bus.d_req = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        nv = 0;
        repeat (5) begin @(negedge clk); if (bus.d_valid || bus.m_req) nv++; end
        chk("rst_mid_quiet", nv, 0);
        chk("rst_mid_m_be", {28'b0, bus.m_be}, 32'd0);

        // Back-pressure: 10 extra wait cycles
        do_data(1'b0, 32'h5000, 32'h0, 4'hF, 32'hCAFE_F00D, 10);
`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        chk("perf_d_stall", p_d, 32'd12);
        chk("perf_if_stall", p_if, 32'd12);
        chk("perf_kill", p_k, 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("end_exp_bus_empty", exp_bus.size(), 0);
        chk("end_exp_if_empty", exp_if.size(), 0);
        chk("end_exp_d_empty", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the RV32I core between instruction fetch (IF) and the load/store (MEM) stage. Accepts one transaction at a time and drives the memory request/acknowledge handshake. Returns fetched instructions and load data, and generates the stall signals the pipeline combines with the hazard/flush logic. Data accesses have priority; an IF fetch killed by a flush is discarded.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_valid or if_kill
if_addr  in  ADDR_W  fetch address (PC)
if_kill  in  1  flush: discard the current or pending fetch
if_rdata  out  DATA_W  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle pulse: fetch complete
d_req  in  1  load/store request; held with the d_* inputs stable until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_rdata  out  DATA_W  load data, valid with d_valid
d_valid  out  1  one-cycle pulse: data access complete (loads and stores)
m_req  out  1  memory request; held until m_ack
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables (all ones for fetches)
m_ack  in  1  one-cycle pulse: access done; m_rdata valid in the same cycle
m_rdata  in  DATA_W  memory read data
stall_if  out  1  hold the PC and IF/ID registers
stall_mem  out  1  hold EX/MEM and all earlier stages

Behaviour:
- FSM states: IDLE, D_BUSY, I_BUSY, DONE. Reset to IDLE.
- Reset values: all outputs 0 except m_be = 0 and stall_* (combinational from the request inputs); kill_pending = 0.
- rst_n asserted mid-transaction: m_req drops immediately; the in-flight access is abandoned; no valid pulse is produced.
- IDLE:
  - d_req → D_BUSY, registering d_we/addr/wdata/be onto m_*.
  - else if_req & ~if_kill → I_BUSY, registering m_we = 0, m_addr = if_addr, m_be = all ones.
  - Priority rule: if d_req and if_req are both high, D_BUSY wins.
- D_BUSY / I_BUSY:
  - m_req = 1; the m_* outputs are held stable.
  - Exit on m_ack → DONE: m_req = 0 and m_rdata is registered into d_rdata or if_rdata.
- DONE (one cycle):
  - d_valid pulses after a D_BUSY access.
  - if_valid pulses after an I_BUSY access unless kill_pending is set.
  - Then → IDLE. No back-to-back grant from DONE; the requester drops or changes its request in the DONE cycle.
- Non-preemptive: a d_req arriving during I_BUSY waits for that fetch to finish.
- Minimum latency: request in cycle 0, m_req in cycle 1, m_ack in cycle 1 at the earliest, valid in cycle 2.
- if_kill:
  - In IDLE: suppresses the fetch start that cycle.
  - In I_BUSY or DONE: sets kill_pending, the fetch completes on the bus, and if_valid is suppressed.
  - kill_pending clears on entry to IDLE.
- Stalls (combinational):
  - stall_mem = d_req & ~d_valid.
  - stall_if = stall_mem | (if_req & ~if_valid & ~if_kill).
- m_ack outside D_BUSY/I_BUSY: ignored.
- The arbiter holds no data buffering beyond the single registered transaction.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_stall_cnt [31:0], perf_d_stall_cnt [31:0] and perf_kill_cnt [31:0].
  - Counters increment on cycles where stall_if is high, on cycles where stall_mem is high, and on each suppressed if_valid, respectively.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, D_BUSY, I_BUSY, DONE), ADDR_W/DATA_W defaults, localparam BE_ALL = all ones.
- Optional sub-module mem_arb_perf: the saturating counters, instantiated only under MEM_ARB_PERF_EN.
- FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Fetch only: if_req with if_addr=0x100, m_ack in cycle 3 with m_rdata=0x00500093 → m_addr=0x100, m_be=4'hF; if_valid pulses in cycle 4 with if_rdata=0x00500093; stall_if high in cycles 0-3.
- Collision: if_req and d_req both high in cycle 0 with a load of d_addr=0x2000 → data access granted first; d_valid, then if fetch starts from IDLE; stall_if high throughout.
- Store: d_req, d_we=1, d_be=4'b0011, d_wdata=0xABCD → m_we=1, m_be=4'b0011; d_valid pulses after m_ack; if_valid stays 0.
- Kill in flight: I_BUSY with addr 0x200, if_kill in cycle 2, m_ack in cycle 4 → no if_valid pulse; next if_req 0x300 fetched normally.
- Reset mid-access: rst_n low during D_BUSY → m_req=0 immediately, FSM in IDLE, no d_valid after release.
- Back-pressure: m_ack delayed 10 cycles → m_req and m_addr stable for all 10 cycles; stall_mem held; under MEM_ARB_PERF_EN, perf_d_stall_cnt = 12.
